// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding from EX/MEM and MEM/WB.
// Feeds the ALU operands/control and carries the memory/writeback control bits forward.
module id_ex_operand_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic [2:0]        id_alu_ctrl,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              exmem_reg_write,
  input  logic [RA_W-1:0]   exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [RA_W-1:0]   memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctrl,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [RA_W-1:0]   ex_dest,
  output logic [RA_W-1:0]   ex_rs,
  output logic [RA_W-1:0]   ex_rt,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  logic              valid_q, valid_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              alu_src_q, alu_src_d;
  logic              reg_dst_q, reg_dst_d;
  logic [2:0]        alu_ctrl_q, alu_ctrl_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [RA_W-1:0]   rs_q, rs_d;
  logic [RA_W-1:0]   rt_q, rt_d;
  logic [RA_W-1:0]   rd_q, rd_d;

  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    alu_src_d    = alu_src_q;
    reg_dst_d    = reg_dst_q;
    alu_ctrl_d   = alu_ctrl_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    if (flush) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      alu_src_d    = 1'b0;
      reg_dst_d    = 1'b0;
      alu_ctrl_d   = '0;
      rs_data_d    = '0;
      rt_data_d    = '0;
      imm_d        = '0;
      rs_d         = '0;
      rt_d         = '0;
      rd_d         = '0;
    end else if (!stall) begin
      // Control is gated by id_valid so an invalid ID slot enters as a bubble.
      valid_d      = id_valid;
      reg_write_d  = id_reg_write & id_valid;
      mem_read_d   = id_mem_read & id_valid;
      mem_write_d  = id_mem_write & id_valid;
      mem_to_reg_d = id_mem_to_reg & id_valid;
      alu_src_d    = id_alu_src & id_valid;
      reg_dst_d    = id_reg_dst & id_valid;
      alu_ctrl_d   = id_alu_ctrl;
      rs_data_d    = id_rs_data;
      rt_data_d    = id_rt_data;
      imm_d        = id_imm;
      rs_d         = id_rs;
      rt_d         = id_rt;
      rd_d         = id_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      reg_dst_q    <= 1'b0;
      alu_ctrl_q   <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_src_q    <= alu_src_d;
      reg_dst_q    <= reg_dst_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
    end
  end

  // EX/MEM is the younger producer, so it wins; r0 is hardwired zero and never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_q)) begin
      fwd_a = 2'b10;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_q)) begin
      fwd_a = 2'b01;
    end
    fwd_b = 2'b00;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_q)) begin
      fwd_b = 2'b10;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_q)) begin
      fwd_b = 2'b01;
    end
  end

  always_comb begin
    unique case (fwd_a)
      2'b10:   alu_a = exmem_result;
      2'b01:   alu_a = memwb_result;
      default: alu_a = rs_data_q;
    endcase
    unique case (fwd_b)
      2'b10:   ex_store_data = exmem_result;
      2'b01:   ex_store_data = memwb_result;
      default: ex_store_data = rt_data_q;
    endcase
    alu_b = alu_src_q ? imm_q : ex_store_data;
  end

  assign alu_ctrl      = alu_ctrl_q;
  assign ex_dest       = reg_dst_q ? rd_q : rt_q;
  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed literal checks plus randomized traffic compared
// every cycle against a behavioural model of the ID/EX stage.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_alu_src, id_reg_dst;
  logic [2:0]  id_alu_ctrl;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  alu_ctrl;
  logic [4:0]  ex_dest, ex_rs, ex_rt;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [1:0]  fwd_a, fwd_b;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DATA_W(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_alu_ctrl(id_alu_ctrl),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data),
    .ex_dest(ex_dest), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  // Model: the instruction currently occupying EX, as the decoder described it.
  typedef struct {
    bit          valid, rw, mr, mw, m2r, alu_src, reg_dst;
    logic [2:0]  ctrl;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
  } instr_t;

  instr_t m;

  function automatic instr_t bubble();
    instr_t b;
    b.valid = 0; b.rw = 0; b.mr = 0; b.mw = 0; b.m2r = 0; b.alu_src = 0; b.reg_dst = 0;
    b.ctrl = 0; b.rs_data = 0; b.rt_data = 0; b.imm = 0; b.rs = 0; b.rt = 0; b.rd = 0;
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      m = bubble();
    end else if (!stall) begin
      m.valid = id_valid;
      m.rw = id_reg_write && id_valid;   m.mr = id_mem_read && id_valid;
      m.mw = id_mem_write && id_valid;   m.m2r = id_mem_to_reg && id_valid;
      m.alu_src = id_alu_src && id_valid; m.reg_dst = id_reg_dst && id_valid;
      m.ctrl = id_alu_ctrl; m.rs_data = id_rs_data; m.rt_data = id_rt_data; m.imm = id_imm;
      m.rs = id_rs; m.rt = id_rt; m.rd = id_rd;
    end
  end

  // Source of the newest value of register r, visible to EX.
  function automatic logic [1:0] src_of(logic [4:0] r);
    if (r == 0) return 2'b00;
    if (exmem_reg_write && exmem_rd == r) return 2'b10;
    if (memwb_reg_write && memwb_rd == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] value_of(logic [4:0] r, logic [31:0] file_val);
    logic [1:0] s;
    s = src_of(r);
    if (s == 2'b10) return exmem_result;
    if (s == 2'b01) return memwb_result;
    return file_val;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] rt_val;
      rt_val = value_of(m.rt, m.rt_data);
      chk("m_alu_a", alu_a, value_of(m.rs, m.rs_data));
      chk("m_store", ex_store_data, rt_val);
      chk("m_alu_b", alu_b, m.alu_src ? m.imm : rt_val);
      chk("m_fwd_a", {30'd0, fwd_a}, {30'd0, src_of(m.rs)});
      chk("m_fwd_b", {30'd0, fwd_b}, {30'd0, src_of(m.rt)});
      chk("m_ctrl", {29'd0, alu_ctrl}, {29'd0, m.ctrl});
      chk("m_dest", {27'd0, ex_dest}, {27'd0, m.reg_dst ? m.rd : m.rt});
      chk("m_rs_rt", {22'd0, ex_rs, ex_rt}, {22'd0, m.rs, m.rt});
      chk("m_ctl_bits", {27'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
                         ex_mem_to_reg}, {27'd0, m.valid, m.rw, m.mr, m.mw, m.m2r});
    end
  end

  task automatic clear_in();
    stall = 0; flush = 0; id_valid = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_alu_src = 0; id_reg_dst = 0; id_alu_ctrl = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  // Advance one clock; returns just after the following negedge so inputs can be changed.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic randomize_in();
    stall = ($urandom_range(0, 7) == 0);
    flush = ($urandom_range(0, 15) == 0);
    id_valid = ($urandom_range(0, 3) != 0);
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
    id_rd = 5'($urandom_range(0, 31));
    id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom); id_alu_ctrl = 3'($urandom);
    id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
    id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
    exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3));
    exmem_result = $urandom;
    memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
    memwb_result = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    #1 rst = 1'b0;

    // Reset then idle
    cyc();
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_ctrl_dest", {24'd0, alu_ctrl, ex_dest}, 32'd0);
    chk("rst_flags", {28'd0, ex_valid, ex_reg_write, fwd_a == 2'b00, fwd_b == 2'b00},
        32'h3);

    // Plain load
    #1;
    id_valid = 1; id_rs_data = 5; id_rt_data = 7; id_alu_ctrl = 3'b010;
    id_reg_dst = 1; id_rd = 9; id_rs = 1; id_rt = 2; id_reg_write = 1;
    cyc();
    chk("plain_alu_a", alu_a, 32'd5);
    chk("plain_alu_b", alu_b, 32'd7);
    chk("plain_dest", {27'd0, ex_dest}, 32'd9);
    chk("plain_rw", {31'd0, ex_reg_write}, 32'd1);
    chk("plain_ctrl", {29'd0, alu_ctrl}, 32'd2);

    // Double hazard, EX/MEM then MEM/WB
    #1;
    id_rs = 3; id_rt = 3; id_rs_data = 32'hA; id_rt_data = 32'hB; id_reg_dst = 0;
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'h22;
    cyc();
    chk("dh_fwd", {28'd0, fwd_a, fwd_b}, 32'hA);
    chk("dh_alu_a", alu_a, 32'h11);
    chk("dh_alu_b", alu_b, 32'h11);
    #1 exmem_reg_write = 0;
    #1;
    chk("dh_wb_fwd", {28'd0, fwd_a, fwd_b}, 32'h5);
    chk("dh_wb_a", alu_a, 32'h22);
    chk("dh_wb_b", alu_b, 32'h22);

    // Register 0 is never forwarded
    #1;
    memwb_reg_write = 0; id_rs = 0; id_rs_data = 32'h33;
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hFF;
    cyc();
    chk("r0_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("r0_alu_a", alu_a, 32'h33);

    // Immediate operand with forwarded store data
    #1;
    id_alu_src = 1; id_imm = 32'hFFFF_FFFC; id_mem_write = 1; id_reg_write = 0;
    id_rt = 4; id_rt_data = 32'h55; exmem_rd = 4; exmem_result = 32'h40;
    cyc();
    chk("imm_alu_b", alu_b, 32'hFFFF_FFFC);
    chk("imm_store", ex_store_data, 32'h40);
    chk("imm_fwd_b", {30'd0, fwd_b}, 32'd2);
    chk("imm_mw", {31'd0, ex_mem_write}, 32'd1);

    // Stall holds for two cycles
    #1;
    stall = 1; id_imm = 32'h1234; id_mem_write = 0; id_alu_ctrl = 3'b111; id_rs = 7;
    cyc();
    cyc();
    chk("stall_alu_b", alu_b, 32'hFFFF_FFFC);
    chk("stall_mw_ctrl", {28'd0, ex_mem_write, alu_ctrl}, 32'hA);

    // Flush beats stall
    #1 flush = 1;
    cyc();
    chk("flush_ctl", {27'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
                      ex_mem_to_reg}, 32'd0);
    chk("flush_ctrl", {29'd0, alu_ctrl}, 32'd0);
    chk("flush_alu_b", alu_b, 32'd0);

    // id_valid=0 loads a bubble
    #1;
    stall = 0; flush = 0; id_valid = 0; id_reg_write = 1; id_mem_read = 1;
    cyc();
    chk("bubble_rw", {30'd0, ex_reg_write, ex_mem_read}, 32'd0);
    chk("bubble_valid", {31'd0, ex_valid}, 32'd0);

    // Randomized traffic, with one asynchronous reset mid-stream
    for (int i = 0; i < 600; i++) begin
      #1 randomize_in();
      if (i == 300) begin
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", {30'd0, ex_valid, ex_reg_write}, 32'd0);
        chk("async_rst_ctrl", {29'd0, alu_ctrl}, 32'd0);
        rst = 1'b0;
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-stage operand forwarding for the 5-stage MIPS pipeline.
- Sits directly upstream of the ALU and drives its a, b and 3-bit ctrl inputs.
- Latches decoded operands and control each cycle.
- Resolves RAW hazards by selecting operands from the EX/MEM or MEM/WB results, and supports stall (hold) and flush (bubble insertion).

Parameters:
DATA_W, 32, datapath width
RA_W, 5, register address width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
stall  in  1  hold stage contents
flush  in  1  replace stage contents with bubble
id_valid  in  1  ID holds a real instruction
id_rs_data  in  DATA_W  register file rs read data
id_rt_data  in  DATA_W  register file rt read data
id_imm  in  DATA_W  sign-extended immediate
id_rs  in  RA_W  rs address
id_rt  in  RA_W  rt address
id_rd  in  RA_W  rd address
id_alu_src  in  1  1: operand b = immediate
id_reg_dst  in  1  1: destination = rd, 0: rt
id_alu_ctrl  in  3  ALU op (000 and, 001 or, 010 add, 110 sub, 111 slt)
id_reg_write  in  1  writes register file
id_mem_read  in  1  load
id_mem_write  in  1  store
id_mem_to_reg  in  1  writeback from memory
exmem_reg_write  in  1  EX/MEM instruction writes a register
exmem_rd  in  RA_W  EX/MEM destination
exmem_result  in  DATA_W  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB instruction writes a register
memwb_rd  in  RA_W  MEM/WB destination
memwb_result  in  DATA_W  MEM/WB writeback value
alu_a  out  DATA_W  ALU operand a
alu_b  out  DATA_W  ALU operand b
alu_ctrl  out  3  ALU control
ex_store_data  out  DATA_W  forwarded rt value for stores
ex_dest  out  RA_W  selected destination register
ex_rs  out  RA_W  latched rs (for hazard unit)
ex_rt  out  RA_W  latched rt (for hazard unit)
ex_valid  out  1  stage holds a real instruction
ex_reg_write  out  1  latched reg_write
ex_mem_read  out  1  latched mem_read
ex_mem_write  out  1  latched mem_write
ex_mem_to_reg  out  1  latched mem_to_reg
fwd_a  out  2  operand a source: 00 reg, 10 EX/MEM, 01 MEM/WB
fwd_b  out  2  operand b (rt path) source, same encoding

Behaviour:
- Reset (async, rst=1): all stage registers clear to 0. Consequently:
  - alu_a=0, alu_b=0, alu_ctrl=000, ex_store_data=0, ex_dest=0.
  - ex_valid and all ex_* control bits = 0; fwd_a=fwd_b=00.
  - Reset asserted mid-operation discards the in-flight instruction immediately.
- Register update on the rising clk edge, priority flush > stall > load:
  - flush=1: ex_valid and all control bits (reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst) cleared. Data, address and alu_ctrl fields cleared to 0. Flush wins over a simultaneous stall.
  - stall=1, flush=0: every register holds its value.
  - Otherwise: all id_* fields are latched. Control bits are latched ANDed with id_valid, so id_valid=0 loads a bubble.
- Stage latency: one cycle, ID to EX.
- Forwarding, combinational from the registered stage and the live exmem_*/memwb_* inputs:
  - fwd_a=10 if exmem_reg_write, exmem_rd!=0 and exmem_rd==ex_rs.
  - Else fwd_a=01 if memwb_reg_write, memwb_rd!=0 and memwb_rd==ex_rs.
  - Else fwd_a=00. fwd_b uses the same rule with ex_rt.
  - EX/MEM has priority over MEM/WB when both match.
  - Register 0 is never forwarded.
- Operands:
  - alu_a = fwd_a-selected rs value.
  - ex_store_data = fwd_b-selected rt value.
  - alu_b = latched imm when alu_src=1, else ex_store_data. fwd_b is still computed and reported when alu_src=1.
- ex_dest = latched rd if reg_dst=1, else latched rt.
- alu_ctrl = latched id_alu_ctrl; ALU arithmetic is unchanged by this block.
- Forwarding is not qualified by ex_valid. A bubble has all control bits 0, so its operands are don't-care downstream.
- Load-use stalls are the hazard unit's job. This block only honours stall/flush.

Test Plan:
- Reset then idle: rst pulse -> all outputs 0, fwd_a=fwd_b=00.
- Plain load: id_rs_data=5, id_rt_data=7, alu_src=0, alu_ctrl=010, reg_dst=1, rd=9, no forwarding -> next cycle alu_a=5, alu_b=7, ex_dest=9, ex_reg_write=1.
- Double hazard: ex_rs=ex_rt=3; exmem_rd=3 (reg_write, result=0x11); memwb_rd=3 (reg_write, result=0x22) -> fwd_a=fwd_b=10, alu_a=alu_b=0x11. Drop exmem_reg_write -> both become 0x22, fwd=01.
- Register 0: ex_rs=0, exmem_rd=0, exmem_reg_write=1, exmem_result=0xFF -> fwd_a=00, alu_a = latched rs data.
- Immediate with store forwarding: alu_src=1, imm=0xFFFFFFFC, mem_write=1, ex_rt matches exmem_rd with result 0x40 -> alu_b=0xFFFFFFFC, ex_store_data=0x40, fwd_b=10.
- Stall/flush: stall=1 for 2 cycles -> outputs frozen. stall=1 and flush=1 together -> ex_valid=0, all control bits 0, alu_ctrl=000. Loading with id_valid=0 -> ex_reg_write=0.
